// File: rtl/rob_pr_free_q_pkg.sv
// rob_pr_free_q_pkg: shared sizes, PR tag type and queue entry layout for rob_pr_free_q.
package rob_pr_free_q_pkg;
    localparam int PR_COUNT              = 128;
    localparam int LOG_PR_COUNT          = 7;
    localparam int PRF_BANK_COUNT        = 4;
    localparam int LOG_PRF_BANK_COUNT    = 2;
    localparam int ROB_PR_FREE_Q_ENTRIES = 2;
    localparam int PTR_W                 = $clog2(ROB_PR_FREE_Q_ENTRIES);

    typedef logic [LOG_PR_COUNT-1:0] pr_t;

    typedef struct packed {
        pr_t [PRF_BANK_COUNT-1:0]  pr;
        logic [PRF_BANK_COUNT-1:0] pending;
    } pr_free_bundle_t;

    function automatic logic [LOG_PRF_BANK_COUNT-1:0] pr_bank(input pr_t p);
        return p[LOG_PRF_BANK_COUNT-1:0];
    endfunction
endpackage

// File: rtl/rob_pr_free_q_bank_select.sv
// pr_free_bank_select: picks the lowest pending lane of one entry whose PR maps to bank BANK.
module pr_free_bank_select
    import rob_pr_free_q_pkg::*;
#(
    parameter int BANK = 0
) (
    input  logic [PRF_BANK_COUNT-1:0]     pending_i,
    input  pr_t  [PRF_BANK_COUNT-1:0]     pr_i,
    output logic                          valid_o,
    output logic [LOG_PRF_BANK_COUNT-1:0] lane_o,
    output pr_t                           pr_o
);
    // Scan high to low so the lowest matching lane wins.
    always_comb begin
        valid_o = 1'b0;
        lane_o  = '0;
        pr_o    = '0;
        for (int l = PRF_BANK_COUNT - 1; l >= 0; l--) begin
            if (pending_i[l] && pr_bank(pr_i[l]) == LOG_PRF_BANK_COUNT'(BANK)) begin
                valid_o = 1'b1;
                lane_o  = LOG_PRF_BANK_COUNT'(l);
                pr_o    = pr_i[l];
            end
        end
    end
endmodule

// File: rtl/rob_pr_free_q.sv
// rob_pr_free_q: in-order queue of freed-PR bundles from ROB commit, drained one PR per free-list bank per cycle.
// Define ROB_PR_FREE_Q_LOOKAHEAD_EN to let idle banks be served from the entry behind the head.
module rob_pr_free_q
    import rob_pr_free_q_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [PRF_BANK_COUNT-1:0]     rob_valid_by_lane_i,
    input  pr_t  [PRF_BANK_COUNT-1:0]     rob_PR_by_lane_i,
    output logic                          rob_ready_o,
    output logic [PRF_BANK_COUNT-1:0]     free_list_valid_by_bank_o,
    output pr_t  [PRF_BANK_COUNT-1:0]     free_list_PR_by_bank_o,
    input  logic [PRF_BANK_COUNT-1:0]     free_list_ready_by_bank_i
);
    localparam int E  = ROB_PR_FREE_Q_ENTRIES;
    localparam int NB = PRF_BANK_COUNT;

    pr_free_bundle_t               mem_q [E];
    pr_free_bundle_t               mem_d [E];
    logic [PTR_W-1:0]              head_q, head_d, tail_q, tail_d, nxt_ptr;
    logic [PTR_W:0]                cnt_q, cnt_d;
    pr_free_bundle_t               hd;
    logic [NB-1:0]                 h_v, n_v, use_nx, head_clr, nx_clr;
    logic [LOG_PRF_BANK_COUNT-1:0] h_l [NB];
    logic [LOG_PRF_BANK_COUNT-1:0] n_l [NB];
    pr_t                           h_pr [NB];
    pr_t                           n_pr [NB];
    logic                          enq, retire;

    assign hd      = mem_q[head_q];
    assign nxt_ptr = head_q + 1'b1;

    for (genvar b = 0; b < NB; b++) begin : g_bank
        pr_free_bank_select #(.BANK(b)) u_hd (
            .pending_i (hd.pending),
            .pr_i      (hd.pr),
            .valid_o   (h_v[b]),
            .lane_o    (h_l[b]),
            .pr_o      (h_pr[b])
        );
`ifdef ROB_PR_FREE_Q_LOOKAHEAD_EN
        pr_free_bank_select #(.BANK(b)) u_nx (
            .pending_i ((cnt_q >= (PTR_W+1)'(2)) ? mem_q[nxt_ptr].pending : '0),
            .pr_i      (mem_q[nxt_ptr].pr),
            .valid_o   (n_v[b]),
            .lane_o    (n_l[b]),
            .pr_o      (n_pr[b])
        );
`else
        assign n_v[b]  = 1'b0;
        assign n_l[b]  = '0;
        assign n_pr[b] = '0;
`endif
    end

    // The head always has priority; the next entry only fills banks the head leaves idle.
    always_comb begin
        head_clr = '0;
        nx_clr   = '0;
        for (int b = 0; b < NB; b++) begin
            use_nx[b]                    = !h_v[b] && n_v[b];
            free_list_valid_by_bank_o[b] = h_v[b] || n_v[b];
            free_list_PR_by_bank_o[b]    = h_v[b] ? h_pr[b] : n_pr[b];
            if (free_list_valid_by_bank_o[b] && free_list_ready_by_bank_i[b]) begin
                if (use_nx[b]) nx_clr[n_l[b]] = 1'b1;
                else head_clr[h_l[b]] = 1'b1;
            end
        end
    end

    assign rob_ready_o = cnt_q != (PTR_W+1)'(E);
    assign enq         = rob_ready_o && |rob_valid_by_lane_i;
    assign retire      = cnt_q != '0 && (hd.pending & ~head_clr) == '0;

    always_comb begin
        mem_d                 = mem_q;
        mem_d[head_q].pending = mem_q[head_q].pending & ~head_clr;
        mem_d[nxt_ptr].pending = mem_q[nxt_ptr].pending & ~nx_clr;
        if (enq) mem_d[tail_q] = '{pr: rob_PR_by_lane_i, pending: rob_valid_by_lane_i};
        head_d = head_q + PTR_W'(retire);
        tail_d = tail_q + PTR_W'(enq);
        cnt_d  = cnt_q + (PTR_W+1)'(enq) - (PTR_W+1)'(retire);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < E; i++) mem_q[i].pending <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            mem_q  <= mem_d;
        end
    end
endmodule
